// File: rtl/ndp_result_tx.sv
// Transmit side of the NDP word stream: captures the wide result vector on the calc-done
// rising edge and sends it as one header word plus NUM_WORDS payload words over valid/ready.
module ndp_result_tx #(
    parameter int WIDTH      = 16,
    parameter int ARR_WIDTH  = 4,
    parameter int ARR_HEIGHT = 4,
    parameter int SYS_WIDTH  = 64,
    parameter int SYS_HEIGHT = 1,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      calc_done_flag,
    input  logic [ARR_WIDTH*SYS_WIDTH*ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0] res_in,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [OUT_WIDTH-1:0]                                      out_data,
    output logic                                                      out_last,
    output logic                                                      tx_busy,
    output logic                                                      overrun,
    output logic                                                      frame_done
);

    localparam int RES_BITS  = ARR_WIDTH * SYS_WIDTH * ARR_HEIGHT * SYS_HEIGHT * WIDTH;
    localparam int NUM_WORDS = RES_BITS / OUT_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_WORDS - 1);
    localparam logic [15:0]      NUM_WORDS16 = 16'(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                 state;
    logic                   done_d;
    logic [7:0]             seq;
    logic [IDX_W-1:0]       word_cnt;
    logic [IDX_W-1:0]       next_cnt;
    logic [OUT_WIDTH-1:0]   buf_words [NUM_WORDS];
    logic                   done_rise;
    logic                   handshake;
    logic                   capture;

    function automatic logic [OUT_WIDTH-1:0] header_word(input logic [7:0] s);
        return OUT_WIDTH'({8'hC5, s, NUM_WORDS16});
    endfunction

    assign done_rise = calc_done_flag & ~done_d;
    assign handshake = out_valid & out_ready;
    assign next_cnt  = word_cnt + IDX_W'(1);
    assign capture   = reset && (state == IDLE) && done_rise;

    // Capture buffer holds the result split into stream words; its contents need no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                buf_words[i] <= res_in[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            done_d     <= 1'b0;
            seq        <= 8'd0;
            word_cnt   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            tx_busy    <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            done_d     <= calc_done_flag;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        state     <= HDR;
                        tx_busy   <= 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_data  <= header_word(seq);
                    end
                end
                HDR: begin
                    if (done_rise) overrun <= 1'b1;
                    if (handshake) begin
                        state    <= DATA;
                        word_cnt <= '0;
                        out_data <= buf_words[0];
                        out_last <= (NUM_WORDS == 1);
                    end
                end
                DATA: begin
                    if (done_rise) overrun <= 1'b1;
                    if (handshake) begin
                        if (word_cnt == LAST_IDX) begin
                            state      <= IDLE;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            tx_busy    <= 1'b0;
                            frame_done <= 1'b1;
                            seq        <= seq + 8'd1;
                        end else begin
                            word_cnt <= next_cnt;
                            out_data <= buf_words[next_cnt];
                            out_last <= (next_cnt == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ndp_result_tx.sv
// Directed bench for ndp_result_tx in the 128-bit result / 4-word payload configuration.
module tb_ndp_result_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic         calc_done_flag;
    logic [127:0] res_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         tx_busy;
    logic         overrun;
    logic         frame_done;

    int vectors = 0;
    int miscompares = 0;

    ndp_result_tx #(
        .WIDTH(16), .ARR_WIDTH(2), .ARR_HEIGHT(2),
        .SYS_WIDTH(2), .SYS_HEIGHT(1), .OUT_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .calc_done_flag(calc_done_flag), .res_in(res_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .tx_busy(tx_busy), .overrun(overrun), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Watches n cycles and reports how many of them had out_valid high.
    task automatic quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    // Called at a sample point where the header is already presented.
    task automatic recv_frame(input logic [31:0] hdr, input logic [127:0] pay,
                              input bit toggle, input int pulse_at);
        logic [7:0]  pat = 8'b10101001;
        logic [31:0] held = '0;
        logic [31:0] exp;
        logic        stalled = 1'b0;
        logic        rdy;
        int          got = 0;
        int          cyc = 0;
        while (got < 5 && cyc < 60) begin
            rdy = toggle ? pat[cyc % 8] : 1'b1;
            if (cyc == pulse_at) calc_done_flag = 1'b1;
            if (cyc == pulse_at + 1) calc_done_flag = 1'b0;
            if (stalled) begin
                chk("stall_data", out_data, held);
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid) begin
                if (rdy) begin
                    exp = (got == 0) ? hdr : pay[(got-1)*32 +: 32];
                    chk($sformatf("word%0d", got), out_data, exp);
                    chk($sformatf("last%0d", got), {31'd0, out_last}, {31'd0, got == 4});
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end
            out_ready = rdy;
            tick();
            cyc++;
        end
        calc_done_flag = 1'b0;
        chk("frame_words", got, 5);
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        chk("end_valid", {31'd0, out_valid}, 32'd0);
        chk("end_busy", {31'd0, tx_busy}, 32'd0);
        out_ready = 1'b0;
        tick();
        chk("frame_done_drop", {31'd0, frame_done}, 32'd0);
    endtask

    task automatic pulse_start();
        calc_done_flag = 1'b1;
        tick();
        calc_done_flag = 1'b0;
        chk("hdr_latency", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p1 = 128'h00000004_00000003_00000002_00000001;
        logic [127:0] p6 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

        reset = 1'b0; calc_done_flag = 1'b0; out_ready = 1'b0; res_in = '0;
        // 1: reset and idle
        repeat (3) tick();
        chk("rst_outs", {26'd0, out_valid, out_last, tx_busy, overrun, frame_done, 1'b0}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        reset = 1'b1;
        quiet("idle_after_reset", 20);

        // 2: clean frame, ready always high
        res_in = p1;
        pulse_start();
        recv_frame(32'hC5000004, p1, 1'b0, -1);

        // 3: same data with stalls, seq now 1
        pulse_start();
        recv_frame(32'hC5010004, p1, 1'b1, -1);

        // 4: overrun during payload, after a fresh reset
        reset = 1'b0; tick(); reset = 1'b1; tick();
        chk("rst_clears_overrun", {31'd0, overrun}, 32'd0);
        pulse_start();
        recv_frame(32'hC5000004, p1, 1'b0, 2);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        quiet("no_second_frame", 10);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        pulse_start();
        recv_frame(32'hC5010004, p1, 1'b0, -1);

        // 5: reset during payload word 2
        pulse_start();
        chk("t5_hdr", out_data, 32'hC5020004);
        out_ready = 1'b1; tick();
        chk("t5_w1", out_data, 32'd1);
        tick();
        chk("t5_w2", out_data, 32'd2);
        reset = 1'b0; tick();
        chk("t5_abort_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_abort_busy", {31'd0, tx_busy}, 32'd0);
        reset = 1'b1; out_ready = 1'b0;
        quiet("t5_no_more_words", 5);
        pulse_start();
        recv_frame(32'hC5000004, p1, 1'b0, -1);

        // 6: long done level, input changed after capture
        res_in = p6;
        calc_done_flag = 1'b1;
        tick();
        res_in = p1;
        chk("t6_hdr_latency", {31'd0, out_valid}, 32'd1);
        recv_frame_hold();
        quiet("t6_single_frame", 6);
        calc_done_flag = 1'b0;
        quiet("t6_after_release", 5);
        chk("t6_no_overrun", {31'd0, overrun}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Receives the test-6 frame while keeping calc_done_flag high throughout.
    task automatic recv_frame_hold();
        logic [127:0] p6 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        logic [31:0]  exp;
        for (int k = 0; k < 5; k++) begin
            exp = (k == 0) ? 32'hC5010004 : p6[(k-1)*32 +: 32];
            chk($sformatf("t6_word%0d", k), out_data, exp);
            chk($sformatf("t6_valid%0d", k), {31'd0, out_valid}, 32'd1);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("t6_frame_done", {31'd0, frame_done}, 32'd1);
    endtask

endmodule
